sample_gather: RTL and testbench

Streaming-to-parallel gatherer that sits directly upstream of the masked multi-input adder tree. Accepts one sample per cycle on a valid/ready stream, packs samples into a NUM_LANES-wide lane vector, and emits each completed frame with a per-lane valid mask suitable for the adder's `din`/`din_ctr` inputs. A frame completes when all lanes are filled or when a sample is flagged `s_last`, which produces a partial frame. A one-deep output register plus the fill buffer give full-rate throughput under no backpressure.

---
 rtl/sample_gather_if.sv | 41 ++++
 rtl/sample_gather.sv | 148 ++++++++++++++
 tb/tb_sample_gather.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_gather_if.sv
// ---------------------------------------------------------------------------
// sample_gather_if
//
// Bundles the input sample stream and the output frame stream of the
// sample gatherer into one interface.
//
//   s_valid / s_ready / s_data / s_last : input sample stream (one sample/beat)
//   m_valid / m_ready                    : output frame handshake
//   m_data                               : unpacked lane array, lane i = i-th sample
//   m_mask                               : per-lane valid mask (contiguous from lane 0)
//   m_count                              : number of samples in the frame
//
// Modports:
//   master : the environment side (drives samples, accepts frames)
//   slave  : the gatherer side
// ---------------------------------------------------------------------------
interface sample_gather_if #(
  parameter int NUM_LANES = 8,
  parameter int WIDTH     = 16,
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_data [NUM_LANES];
  logic [NUM_LANES-1:0] m_mask;
  logic [CNT_W-1:0]     m_count;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_mask, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_mask, m_count
  );
endinterface

// File: rtl/sample_gather.sv
// ---------------------------------------------------------------------------
// sample_gather
//
// Packs a one-sample-per-beat stream into NUM_LANES-wide frames with a
// per-lane valid mask. A frame closes when the last lane is written or when
// a sample carries s_last (partial frame). A fill buffer plus a one-deep
// output register give full throughput when the consumer never stalls.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : sample_gather_if.slave (s_* sample stream in, m_* frame stream out)
// ---------------------------------------------------------------------------
module sample_gather #(
  parameter int NUM_LANES = 8,
  parameter int WIDTH     = 16,
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  sample_gather_if.slave bus
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               state_reg;
  logic                 ready_reg;

  // Fill buffer. fill_cnt_reg doubles as the write index while filling and
  // as the frame sample count while a completed frame waits in HOLD.
  logic [WIDTH-1:0]     fill_lane_reg [NUM_LANES];
  logic [NUM_LANES-1:0] fill_mask_reg;
  logic [CNT_W-1:0]     fill_cnt_reg;

  // Output register.
  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_lane_reg [NUM_LANES];
  logic [NUM_LANES-1:0] out_mask_reg;
  logic [CNT_W-1:0]     out_cnt_reg;

  logic                 accept;
  logic                 complete;
  logic                 out_xfer;
  logic                 slot_free;
  logic [CNT_W-1:0]     cnt_inc;

  // Fill buffer contents with the current sample (if any) merged in; this is
  // what gets written back or forwarded straight to the output register.
  logic [WIDTH-1:0]     lane_merge [NUM_LANES];
  logic [NUM_LANES-1:0] mask_merge;

  // ready_reg is only ever set while in FILL, so it alone qualifies accepts.
  assign accept    = bus.s_valid && ready_reg;
  assign complete  = accept && (bus.s_last || (fill_cnt_reg == CNT_W'(NUM_LANES - 1)));
  assign out_xfer  = out_valid_reg && bus.m_ready;
  assign slot_free = !out_valid_reg || bus.m_ready;
  assign cnt_inc   = fill_cnt_reg + CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic hit;
      assign hit             = accept && (fill_cnt_reg == CNT_W'(gi));
      assign lane_merge[gi]  = hit ? bus.s_data : fill_lane_reg[gi];
      assign mask_merge[gi]  = hit | fill_mask_reg[gi];
      assign bus.m_data[gi]  = out_lane_reg[gi];
    end
  endgenerate

  assign bus.s_ready = ready_reg;
  assign bus.m_valid = out_valid_reg;
  assign bus.m_mask  = out_mask_reg;
  assign bus.m_count = out_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      ready_reg     <= 1'b0;
      fill_mask_reg <= '0;
      fill_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_mask_reg  <= '0;
      out_cnt_reg   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        fill_lane_reg[i] <= '0;
        out_lane_reg[i]  <= '0;
      end
    end else begin
      // Frame leaves; a load below may refill the slot on the same edge.
      if (out_xfer) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_FILL: begin
          ready_reg <= 1'b1;
          if (complete && slot_free) begin
            // Bypass the fill buffer: completed frame goes straight out.
            out_valid_reg <= 1'b1;
            out_lane_reg  <= lane_merge;
            out_mask_reg  <= mask_merge;
            out_cnt_reg   <= cnt_inc;
            fill_mask_reg <= '0;
            fill_cnt_reg  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
              fill_lane_reg[i] <= '0;
            end
          end else if (accept) begin
            fill_lane_reg <= lane_merge;
            fill_mask_reg <= mask_merge;
            fill_cnt_reg  <= cnt_inc;
            if (complete) begin
              // Output slot busy: park the frame and stop accepting.
              state_reg <= ST_HOLD;
              ready_reg <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          ready_reg <= 1'b0;
          if (slot_free) begin
            out_valid_reg <= 1'b1;
            out_lane_reg  <= fill_lane_reg;
            out_mask_reg  <= fill_mask_reg;
            out_cnt_reg   <= fill_cnt_reg;
            fill_mask_reg <= '0;
            fill_cnt_reg  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
              fill_lane_reg[i] <= '0;
            end
            state_reg <= ST_FILL;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_FILL;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_gather.sv
// ---------------------------------------------------------------------------
// tb_sample_gather
//
// Directed bench for sample_gather: an 8-lane x 16-bit instance for the main
// scenarios and a 2-lane instance for the degenerate size.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sample_gather;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sample_gather_if #(.NUM_LANES(8), .WIDTH(16)) bus8 ();
  sample_gather_if #(.NUM_LANES(2), .WIDTH(16)) bus2 ();

  sample_gather #(.NUM_LANES(8), .WIDTH(16)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  sample_gather #(.NUM_LANES(2), .WIDTH(16)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Frames captured at each output transfer.
  logic [127:0] cap8_data [$];
  logic [7:0]   cap8_mask [$];
  logic [3:0]   cap8_cnt  [$];
  logic [31:0]  cap2_data [$];
  logic [1:0]   cap2_mask [$];
  logic [1:0]   cap2_cnt  [$];

  function automatic logic [127:0] frame8();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = bus8.m_data[i];
    return v;
  endfunction

  function automatic logic [31:0] frame2();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 2; i++) v[i*16 +: 16] = bus2.m_data[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst && bus8.m_valid && bus8.m_ready) begin
      cap8_data.push_back(frame8());
      cap8_mask.push_back(bus8.m_mask);
      cap8_cnt.push_back(bus8.m_count);
    end
    if (!rst && bus2.m_valid && bus2.m_ready) begin
      cap2_data.push_back(frame2());
      cap2_mask.push_back(bus2.m_mask);
      cap2_cnt.push_back(bus2.m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    bus8.s_valid = 1'b1;
    bus8.s_data  = d;
    bus8.s_last  = last;
    while (!bus8.s_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus8.s_ready) begin
      errors++;
      $display("FAIL send8_timeout: s_ready=%0b required 1 for sample %h", bus8.s_ready, d);
    end
    step();
    bus8.s_valid = 1'b0;
    bus8.s_last  = 1'b0;
  endtask

  task automatic send2(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    bus2.s_valid = 1'b1;
    bus2.s_data  = d;
    bus2.s_last  = last;
    while (!bus2.s_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus2.s_ready) begin
      errors++;
      $display("FAIL send2_timeout: s_ready=%0b required 1 for sample %h", bus2.s_ready, d);
    end
    step();
    bus2.s_valid = 1'b0;
    bus2.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus8.s_ready, bus8.m_valid, bus8.m_mask, bus8.m_count} !== 14'd0 || frame8() !== 128'd0) begin
      errors++;
      $display("FAIL reset8_outputs: rdy=%0b val=%0b mask=%h cnt=%0d data=%h required all zero",
               bus8.s_ready, bus8.m_valid, bus8.m_mask, bus8.m_count, frame8());
    end
    checks++;
    if ({bus2.s_ready, bus2.m_valid, bus2.m_mask, bus2.m_count} !== 6'd0 || frame2() !== 32'd0) begin
      errors++;
      $display("FAIL reset2_outputs: rdy=%0b val=%0b mask=%h cnt=%0d required all zero",
               bus2.s_ready, bus2.m_valid, bus2.m_mask, bus2.m_count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus8.s_ready !== 1'b1 || bus2.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_ready8=%0b s_ready2=%0b required 1", bus8.s_ready, bus2.s_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    cap8_data.delete(); cap8_mask.delete(); cap8_cnt.delete();
    for (int i = 1; i <= 8; i++) send8(16'(i), 1'b0);
    checks++;
    if (bus8.m_valid !== 1'b1 || bus8.m_mask !== 8'hFF || bus8.m_count !== 4'd8 ||
        frame8() !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
      errors++;
      $display("FAIL full_frame: val=%0b mask=%h cnt=%0d data=%h required 1 ff 8 0008..0001",
               bus8.m_valid, bus8.m_mask, bus8.m_count, frame8());
    end
    step();
    checks++;
    if (bus8.m_valid !== 1'b0 || cap8_data.size() != 1) begin
      errors++;
      $display("FAIL full_frame_one_cycle: m_valid=%0b frames=%0d required 0 and 1",
               bus8.m_valid, cap8_data.size());
    end
    $display("test_full_frame: frame mask=ff cnt=8");
  endtask

  task automatic test_partial_frame();
    send8(16'hA, 1'b0);
    send8(16'hB, 1'b0);
    send8(16'hC, 1'b1);
    checks++;
    if (bus8.m_valid !== 1'b1 || bus8.m_mask !== 8'h07 || bus8.m_count !== 4'd3 ||
        frame8() !== 128'h0000_0000_0000_0000_0000_000C_000B_000A) begin
      errors++;
      $display("FAIL partial_frame: val=%0b mask=%h cnt=%0d data=%h required 1 07 3 ..000c000b000a",
               bus8.m_valid, bus8.m_mask, bus8.m_count, frame8());
    end
    send8(16'hD, 1'b1);
    checks++;
    if (bus8.m_mask !== 8'h01 || bus8.m_count !== 4'd1 || frame8() !== 128'h000D) begin
      errors++;
      $display("FAIL partial_next_lane0: mask=%h cnt=%0d data=%h required 01 1 000d",
               bus8.m_mask, bus8.m_count, frame8());
    end
    step();
    $display("test_partial_frame: frames mask=07 then 01");
  endtask

  task automatic test_backpressure();
    cap8_data.delete(); cap8_mask.delete(); cap8_cnt.delete();
    bus8.m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send8(16'h0100 + 16'(i), 1'b0);
    checks++;
    if (bus8.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_drop: s_ready=%0b required 0", bus8.s_ready);
    end
    checks++;
    if (bus8.m_valid !== 1'b1 || bus8.m_count !== 4'd8 ||
        frame8() !== 128'h0108_0107_0106_0105_0104_0103_0102_0101) begin
      errors++;
      $display("FAIL bp_first_stable: val=%0b cnt=%0d data=%h required 1 8 0108..0101",
               bus8.m_valid, bus8.m_count, frame8());
    end
    bus8.m_ready = 1'b1;
    step();
    bus8.m_ready = 1'b0;
    checks++;
    if (bus8.s_ready !== 1'b1 || bus8.m_valid !== 1'b1 ||
        frame8() !== 128'h0110_010F_010E_010D_010C_010B_010A_0109) begin
      errors++;
      $display("FAIL bp_second_loaded: rdy=%0b val=%0b data=%h required 1 1 0110..0109",
               bus8.s_ready, bus8.m_valid, frame8());
    end
    bus8.m_ready = 1'b1;
    step();
    checks++;
    if (cap8_data.size() != 2 || bus8.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_frame_count: frames=%0d m_valid=%0b required 2 and 0",
               cap8_data.size(), bus8.m_valid);
    end else begin
      checks++;
      if (cap8_data[0] !== 128'h0108_0107_0106_0105_0104_0103_0102_0101 ||
          cap8_data[1] !== 128'h0110_010F_010E_010D_010C_010B_010A_0109) begin
        errors++;
        $display("FAIL bp_order: f0=%h f1=%h required 0108..0101 then 0110..0109",
                 cap8_data[0], cap8_data[1]);
      end
    end
    $display("test_backpressure: two frames drained in order");
  endtask

  task automatic test_back_to_back();
    int t0;
    cap8_data.delete(); cap8_mask.delete(); cap8_cnt.delete();
    t0 = cyc;
    for (int i = 1; i <= 24; i++) send8(16'(i), (i == 2 || i == 10 || i == 24));
    checks++;
    if (cyc - t0 != 24) begin
      errors++;
      $display("FAIL b2b_throughput: cycles=%0d required 24", cyc - t0);
    end
    step();
    checks++;
    if (cap8_cnt.size() != 4) begin
      errors++;
      $display("FAIL b2b_frame_count: frames=%0d required 4", cap8_cnt.size());
    end else begin
      checks++;
      if (cap8_cnt[0] !== 4'd2 || cap8_cnt[1] !== 4'd8 || cap8_cnt[2] !== 4'd8 || cap8_cnt[3] !== 4'd6 ||
          cap8_mask[0] !== 8'h03 || cap8_mask[3] !== 8'h3F) begin
        errors++;
        $display("FAIL b2b_counts: cnt=%0d,%0d,%0d,%0d mask0=%h mask3=%h required 2,8,8,6 03 3f",
                 cap8_cnt[0], cap8_cnt[1], cap8_cnt[2], cap8_cnt[3], cap8_mask[0], cap8_mask[3]);
      end
      checks++;
      if (cap8_data[0] !== 128'h0002_0001 ||
          cap8_data[1] !== 128'h000A_0009_0008_0007_0006_0005_0004_0003 ||
          cap8_data[3] !== 128'h0000_0000_0018_0017_0016_0015_0014_0013) begin
        errors++;
        $display("FAIL b2b_data: f0=%h f1=%h f3=%h", cap8_data[0], cap8_data[1], cap8_data[3]);
      end
    end
    $display("test_back_to_back: %0d frames", cap8_cnt.size());
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    for (int i = 1; i <= 5; i++) send8(16'h0030 + 16'(i), 1'b0);
    n0 = cap8_data.size();
    rst = 1'b1;
    bus8.s_valid = 1'b1;
    bus8.s_data  = 16'h0055;
    bus8.s_last  = 1'b1;
    step();
    checks++;
    if ({bus8.s_ready, bus8.m_valid, bus8.m_mask, bus8.m_count} !== 14'd0 || frame8() !== 128'd0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%0b val=%0b mask=%h cnt=%0d data=%h required all zero",
               bus8.s_ready, bus8.m_valid, bus8.m_mask, bus8.m_count, frame8());
    end
    rst = 1'b0;
    bus8.s_valid = 1'b0;
    bus8.s_last  = 1'b0;
    repeat (2) step();
    checks++;
    if (cap8_data.size() != n0 || bus8.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_frame: frames=%0d m_valid=%0b required %0d and 0",
               cap8_data.size(), bus8.m_valid, n0);
    end
    for (int i = 1; i <= 8; i++) send8(16'h0200 + 16'(i), 1'b0);
    checks++;
    if (bus8.m_mask !== 8'hFF || bus8.m_count !== 4'd8 ||
        frame8() !== 128'h0208_0207_0206_0205_0204_0203_0202_0201) begin
      errors++;
      $display("FAIL midreset_clean_frame: mask=%h cnt=%0d data=%h required ff 8 0208..0201",
               bus8.m_mask, bus8.m_count, frame8());
    end
    step();
    $display("test_reset_mid_frame: clean frame after reset");
  endtask

  task automatic test_degenerate();
    cap2_data.delete(); cap2_mask.delete(); cap2_cnt.delete();
    send2(16'h0011, 1'b1);
    send2(16'h0022, 1'b0);
    send2(16'h0033, 1'b1);
    send2(16'h0044, 1'b1);
    send2(16'h0055, 1'b0);
    send2(16'h0066, 1'b0);
    step();
    checks++;
    if (cap2_data.size() != 4) begin
      errors++;
      $display("FAIL deg_frame_count: frames=%0d required 4", cap2_data.size());
    end else begin
      checks++;
      if (cap2_mask[0] !== 2'b01 || cap2_mask[1] !== 2'b11 || cap2_mask[2] !== 2'b01 || cap2_mask[3] !== 2'b11 ||
          cap2_cnt[0] !== 2'd1 || cap2_cnt[1] !== 2'd2) begin
        errors++;
        $display("FAIL deg_masks: masks=%b,%b,%b,%b cnt0=%0d cnt1=%0d required 01,11,01,11 1 2",
                 cap2_mask[0], cap2_mask[1], cap2_mask[2], cap2_mask[3], cap2_cnt[0], cap2_cnt[1]);
      end
      checks++;
      if (cap2_data[0] !== 32'h0000_0011 || cap2_data[1] !== 32'h0033_0022 ||
          cap2_data[2] !== 32'h0000_0044 || cap2_data[3] !== 32'h0066_0055) begin
        errors++;
        $display("FAIL deg_data: %h %h %h %h required 00000011 00330022 00000044 00660055",
                 cap2_data[0], cap2_data[1], cap2_data[2], cap2_data[3]);
      end
    end
    $display("test_degenerate: %0d frames", cap2_data.size());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.s_last = 1'b0; bus8.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_last = 1'b0; bus2.m_ready = 1'b1;
    #1;
    test_reset();
    test_full_frame();
    test_partial_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
